// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule C/D rotation sequencer.
// Latches a post-PC-1 key (C||D) and presents the 16 round values of C||D, one
// per valid/ready transfer. Encrypt rotates left each round. Decrypt starts from
// the unrotated key, which equals encrypt round 15, and walks back with right
// rotations.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; sk_round and sk_cd held at 0
// RUN   | sk_cd/sk_round valid; advance on each sk_valid & sk_ready
module des_key_sched_ctrl #(
    parameter int          HALF_W     = 28,
    parameter logic [15:0] SHIFT_MASK = 16'h8103
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [2*HALF_W-1:0]   key_cd,
    output logic                  idle,
    output logic                  sk_valid,
    input  logic                  sk_ready,
    output logic [2*HALF_W-1:0]   sk_cd,
    output logic [3:0]            sk_round,
    output logic                  done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic                mode, mode_nxt;
    logic [2*HALF_W-1:0] cd_nxt;
    logic [3:0]          round_nxt;
    logic                done_nxt;
    logic [3:0]          round_inc;
    logic [3:0]          shift_idx;
    logic                xfer;

    // Rotate one half by 1 or 2 positions in either direction.
    function automatic logic [HALF_W-1:0] rot_half(input logic [HALF_W-1:0] x,
                                                   input logic left,
                                                   input logic two);
        case ({left, two})
            2'b10:   rot_half = {x[HALF_W-2:0], x[HALF_W-1]};
            2'b11:   rot_half = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
            2'b00:   rot_half = {x[0], x[HALF_W-1:1]};
            default: rot_half = {x[1:0], x[HALF_W-1:2]};
        endcase
    endfunction

    // C and D rotate independently, never carrying bits across the boundary.
    function automatic logic [2*HALF_W-1:0] rot_cd(input logic [2*HALF_W-1:0] x,
                                                   input logic left,
                                                   input logic two);
        rot_cd = {rot_half(x[2*HALF_W-1:HALF_W], left, two),
                  rot_half(x[HALF_W-1:0], left, two)};
    endfunction

    assign idle      = (state == S_IDLE);
    assign sk_valid  = (state == S_RUN);
    assign xfer      = sk_valid & sk_ready;
    assign round_inc = sk_round + 4'd1;
    // Decrypt round r undoes encrypt round 16-r, i.e. index 15 - (r-1).
    assign shift_idx = mode ? (4'd15 - sk_round) : round_inc;

    // Next-state and next-datapath logic.
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        cd_nxt    = sk_cd;
        round_nxt = sk_round;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    mode_nxt  = decrypt;
                    round_nxt = 4'd0;
                    cd_nxt    = decrypt ? key_cd : rot_cd(key_cd, 1'b1, ~SHIFT_MASK[0]);
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (sk_round == 4'd15) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                        round_nxt = 4'd0;
                        cd_nxt    = '0;
                    end else begin
                        round_nxt = round_inc;
                        cd_nxt    = rot_cd(sk_cd, ~mode, ~SHIFT_MASK[shift_idx]);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode     <= 1'b0;
            sk_cd    <= '0;
            sk_round <= 4'd0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mode     <= mode_nxt;
            sk_cd    <= cd_nxt;
            sk_round <= round_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Directed bench for des_key_sched_ctrl: table of spot values plus full
// schedule walks with backpressure, ignored restart, and mid-run reset.
module tb_des_key_sched_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [55:0] key_cd;
    logic        idle;
    logic        sk_valid;
    logic        sk_ready;
    logic [55:0] sk_cd;
    logic [3:0]  sk_round;
    logic        done;

    int checks = 0;
    int errors = 0;

    des_key_sched_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .decrypt  (decrypt),
        .key_cd   (key_cd),
        .idle     (idle),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .sk_cd    (sk_cd),
        .sk_round (sk_round),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dec;
        logic [55:0] key;
        int          rnd;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs[12];

    localparam logic [55:0] KEY_A = 56'hF0CCAAF_556678F;
    localparam logic [55:0] KEY_B = 56'h0000001_0000001;
    localparam logic [55:0] KEY_X = 56'h123456789ABCDE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: round value as a single cumulative rotation of the original key.
    function automatic logic [55:0] model(input logic dec, input logic [55:0] key, input int r);
        logic [15:0] m;
        logic [27:0] c;
        logic [27:0] d;
        int idx;
        int tot;
        m   = 16'h8103;
        idx = dec ? 15 - r : r;
        tot = 0;
        for (int i = 0; i <= idx; i++) tot += m[i] ? 1 : 2;
        c = key[55:28];
        d = key[27:0];
        for (int i = 0; i < tot; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    // Run one schedule with sk_ready=1, sample the value at round rnd, drain to done.
    task automatic run_capture(input logic dec, input logic [55:0] key, input int rnd,
                               output logic [55:0] cd, output logic [3:0] rn);
        int n;
        start = 1'b1; decrypt = dec; key_cd = key; sk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; decrypt = ~dec; key_cd = KEY_X;
        repeat (rnd) @(negedge clk);
        cd = sk_cd;
        rn = sk_round;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("capture_timeout", 64'(n), 64'd16);
    endtask

    // Full schedule walk; ends on the negedge of the done cycle (or after a reset).
    task automatic do_sched(input logic dec, input logic [55:0] key,
                            input int hold_at, input int hold_n,
                            input int start_at, input int rst_at);
        int exp_r;
        int held;
        int cycles;
        bit restarted;
        exp_r = 0; held = 0; cycles = 0; restarted = 0;
        start = 1'b1; decrypt = dec; key_cd = key; sk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; decrypt = ~dec; key_cd = KEY_X;
        while (exp_r < 16 && cycles < 100) begin
            chk("run_valid", 64'(sk_valid), 64'd1);
            chk("run_idle", 64'(idle), 64'd0);
            chk("run_done", 64'(done), 64'd0);
            chk("run_round", 64'(sk_round), 64'(exp_r));
            chk("run_cd", 64'(sk_cd), 64'(model(dec, key, exp_r)));
            if (exp_r == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_idle", 64'(idle), 64'd1);
                chk("rst_valid", 64'(sk_valid), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_round", 64'(sk_round), 64'd0);
                return;
            end
            if (exp_r == start_at && !restarted) begin
                start = 1'b1; decrypt = ~dec; key_cd = KEY_X;
                restarted = 1;
            end
            if (exp_r == hold_at && held < hold_n) begin
                sk_ready = 1'b0;
                held++;
            end else begin
                sk_ready = 1'b1;
                exp_r++;
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        if (exp_r < 16) chk("sched_timeout", 64'(exp_r), 64'd16);
        chk("end_done", 64'(done), 64'd1);
        chk("end_idle", 64'(idle), 64'd1);
        chk("end_valid", 64'(sk_valid), 64'd0);
        chk("end_round", 64'(sk_round), 64'd0);
    endtask

    initial begin
        logic [55:0] cd;
        logic [3:0]  rn;

        vecs[0]  = '{1'b0, KEY_A, 0,  56'hE19955F_AACCF1E};
        vecs[1]  = '{1'b0, KEY_A, 1,  56'hC332ABF_5599E3D};
        vecs[2]  = '{1'b0, KEY_A, 2,  56'h0CCAAFF_56678F5};
        vecs[3]  = '{1'b0, KEY_A, 15, 56'hF0CCAAF_556678F};
        vecs[4]  = '{1'b1, KEY_A, 0,  56'hF0CCAAF_556678F};
        vecs[5]  = '{1'b0, KEY_B, 0,  56'h0000002_0000002};
        vecs[6]  = '{1'b0, KEY_B, 1,  56'h0000004_0000004};
        vecs[7]  = '{1'b0, KEY_B, 2,  56'h0000010_0000010};
        vecs[8]  = '{1'b0, KEY_B, 15, 56'h0000001_0000001};
        vecs[9]  = '{1'b1, KEY_B, 0,  56'h0000001_0000001};
        vecs[10] = '{1'b1, KEY_B, 1,  56'h8000000_8000000};
        vecs[11] = '{1'b1, KEY_B, 7,  56'h0008000_0008000};

        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_cd = KEY_X; sk_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_valid", 64'(sk_valid), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_cd", 64'(sk_cd), 64'd0);
        chk("reset_round", 64'(sk_round), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_still_idle", 64'(idle), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_capture(vecs[i].dec, vecs[i].key, vecs[i].rnd, cd, rn);
            chk($sformatf("vec%0d_cd", i), 64'(cd), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_round", i), 64'(rn), 64'(vecs[i].rnd));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'd1);
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);

        // Full encrypt/decrypt walks.
        do_sched(1'b0, KEY_A, -1, 0, -1, -1);
        @(negedge clk);
        chk("post_a_done", 64'(done), 64'd0);
        do_sched(1'b0, KEY_B, -1, 0, -1, -1);
        @(negedge clk);
        do_sched(1'b1, KEY_B, -1, 0, -1, -1);
        @(negedge clk);

        // Backpressure at round 7 for 5 cycles.
        do_sched(1'b0, KEY_A, 7, 5, -1, -1);
        @(negedge clk);
        chk("bp_done_once", 64'(done), 64'd0);

        // Start during RUN ignored; then start in the done cycle itself.
        do_sched(1'b0, KEY_A, -1, 0, 4, -1);
        do_sched(1'b1, KEY_A, 3, 2, -1, -1);
        @(negedge clk);
        chk("chain_done_once", 64'(done), 64'd0);

        // Reset at round 9, then a clean schedule.
        do_sched(1'b0, KEY_A, -1, 0, -1, 9);
        @(negedge clk);
        chk("post_rst_idle", 64'(idle), 64'd1);
        chk("post_rst_done", 64'(done), 64'd0);
        do_sched(1'b1, KEY_B, -1, 0, -1, -1);
        @(negedge clk);
        chk("final_idle", 64'(idle), 64'd1);
        chk("final_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
